// File: rtl/avalon_pkg.sv
// Shared types and helpers for Avalon-MM slaves.
// Holds the wait-state FSM encoding and byte-lane merge.
package avalon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    localparam int WORD_BYTES = 4;

    function automatic logic [31:0] apply_byteenable(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] w;
        w = old_word;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (be[k]) w[8*k +: 8] = new_word[8*k +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/avalon_wait_ram_if.sv
// Avalon-MM bus bundle between the CPU master and the RAM slave.
// Master drives the request; slave answers with stall and data.
interface avalon_wait_ram_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_wait_ctrl.sv
// Wait-state sequencer: IDLE -> WAIT (N cycles) -> ACK.
// Generates waitrequest and a one-cycle completion strobe.
module avalon_wait_ctrl
    import avalon_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic read,
    input  logic write,
    output logic waitrequest,
    output logic done
);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       req;

    assign req = read | write;

    // State and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state; a request that vanishes mid-wait is abandoned.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nx   = 4'(WAIT_CYCLES);
                    state_nx = (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt <= 4'd1) state_nx = ACK;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stall is masked while reset is held so the master sees it drop at once.
    assign waitrequest = req && (state != ACK) && reset;
    assign done        = req && (state == ACK);

endmodule

// File: rtl/avalon_wait_ram.sv
// Word RAM slave behind the CPU with wait states and byte lanes.
// Side-load port preloads words; bus_error latches bad accesses.
module avalon_wait_ram
    import avalon_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    avalon_wait_ram_if.slave   bus,
    input  logic               load_en,
    input  logic [7:0]         load_addr,
    input  logic [31:0]        load_data,
    output logic               bus_error
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [32:0]   diff;
    logic          in_range;
    logic          misaligned;
    logic [AW-1:0] index;
    logic [AW-1:0] load_idx;
    logic          done;
    logic          rd_now;
    logic          wr_now;
    logic          err_now;
    logic [31:0]   rd_word;
    logic [31:0]   rd_q;

    // Borrow bit of the extended subtraction flags addresses below the base.
    assign diff       = {1'b0, bus.address} - {1'b0, BASE_ADDR};
    assign in_range   = !diff[32] && (diff[31:AW+2] == '0);
    assign misaligned = |diff[1:0];
    assign index      = diff[AW+1:2];
    assign load_idx   = AW'(load_addr);

    avalon_wait_ctrl #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .read        (bus.read),
        .write       (bus.write),
        .waitrequest (bus.waitrequest),
        .done        (done)
    );

    assign rd_now  = done && bus.read;
    assign wr_now  = done && bus.write && !bus.read && in_range;
    assign err_now = done && (!in_range || misaligned || (bus.read && bus.write));
    assign rd_word = in_range ? mem[index] : 32'h0;

    assign bus.readdata = rd_now ? rd_word : rd_q;

    // Hold the last completed read and latch sticky errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q      <= '0;
            bus_error <= 1'b0;
        end else begin
            if (rd_now)  rd_q      <= rd_word;
            if (err_now) bus_error <= 1'b1;
        end
    end

    // Memory array; the side-load is ordered last so it wins a collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            if (wr_now) begin
                mem[index] <= apply_byteenable(mem[index], bus.writedata,
                                               bus.byteenable);
            end
            if (load_en) mem[load_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Bench for avalon_wait_ram: scoreboard of expected read data.
// Two instances cover one wait state and zero wait states.
module tb_avalon_wait_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        err1;
    logic        err0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];

    avalon_wait_ram_if bus1 ();
    avalon_wait_ram_if bus0 ();

    always #5 clk = ~clk;

    avalon_wait_ram #(
        .DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)
    ) dut1 (
        .clk(clk), .reset(rst_n), .bus(bus1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .bus_error(err1)
    );

    avalon_wait_ram #(
        .DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .reset(rst_n), .bus(bus0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .bus_error(err0)
    );

    task automatic do_reset;
        rst_n = 1'b0;
        bus1.read = 0; bus1.write = 0; bus1.address = 0;
        bus1.writedata = 0; bus1.byteenable = 0;
        bus0.read = 0; bus0.write = 0; bus0.address = 0;
        bus0.writedata = 0; bus0.byteenable = 0;
        load_en = 0; load_addr = 0; load_data = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic side_load(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk);
        #1 load_en = 1; load_addr = a; load_data = d;
        @(posedge clk);
        #1 load_en = 0;
    endtask

    task automatic xfer1(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be,
                         output int stall, output logic [31:0] rdata);
        @(posedge clk);
        #1;
        bus1.read = rd; bus1.write = wr; bus1.address = addr;
        bus1.writedata = wd; bus1.byteenable = be;
        stall = -1;
        rdata = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus1.waitrequest) begin
                stall = i;
                rdata = bus1.readdata;
                break;
            end
        end
        @(posedge clk);
        #1 bus1.read = 0; bus1.write = 0;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        checks++;
        if (bus1.waitrequest !== 1'b0) begin
            errors++; $display("FAIL reset_wait1 got %b exp 0", bus1.waitrequest);
        end
        checks++;
        if (bus1.readdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata1 got %h exp 0", bus1.readdata);
        end
        checks++;
        if (err1 !== 1'b0) begin
            errors++; $display("FAIL reset_err1 got %b exp 0", err1);
        end
        checks++;
        if (bus0.readdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata0 got %h exp 0", bus0.readdata);
        end
        checks++;
        if (err0 !== 1'b0) begin
            errors++; $display("FAIL reset_err0 got %b exp 0", err0);
        end
    endtask

    task automatic test_sideload_read;
        int          st;
        logic [31:0] rd, want;
        side_load(8'd1, 32'h2402_0010);
        exp_q.push_back(32'h2402_0010);
        xfer1(1, 0, 32'h04, 0, 0, st, rd);
        want = exp_q.pop_front();
        checks++;
        if (st !== 2) begin
            errors++; $display("FAIL sl_read_stall got %0d exp 2", st);
        end
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL sl_read_data got %h exp %h", rd, want);
        end
        checks++;
        if (err1 !== 1'b0) begin
            errors++; $display("FAIL sl_read_err got %b exp 0", err1);
        end
    endtask

    task automatic test_byteenable;
        int          st;
        logic [31:0] rd, want;
        xfer1(0, 1, 32'h08, 32'hAABB_CCDD, 4'b0101, st, rd);
        checks++;
        if (st !== 2) begin
            errors++; $display("FAIL be_write_stall got %0d exp 2", st);
        end
        exp_q.push_back(32'h00BB_00DD);
        xfer1(1, 0, 32'h08, 0, 0, st, rd);
        want = exp_q.pop_front();
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL be_read_data got %h exp %h", rd, want);
        end
        checks++;
        if (err1 !== 1'b0) begin
            errors++; $display("FAIL be_err got %b exp 0", err1);
        end
    endtask

    task automatic test_back_to_back;
        int          st;
        logic [31:0] rd, want;
        for (int k = 0; k < 4; k++) begin
            side_load(8'(k), 32'hC0DE_0000 + 32'(k * 17));
            exp_q.push_back(32'hC0DE_0000 + 32'(k * 17));
        end
        @(posedge clk);
        #1 bus0.read = 1; bus0.address = 32'h0;
        for (int k = 0; k < 4; k++) begin
            st = -1;
            rd = 'x;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!bus0.waitrequest) begin
                    st = i;
                    rd = bus0.readdata;
                    break;
                end
            end
            want = exp_q.pop_front();
            checks++;
            if (st !== 1) begin
                errors++; $display("FAIL b2b_stall[%0d] got %0d exp 1", k, st);
            end
            checks++;
            if (rd !== want) begin
                errors++; $display("FAIL b2b_data[%0d] got %h exp %h", k, rd, want);
            end
            @(posedge clk);
            #1;
            if (k < 3) bus0.address = 32'((k + 1) * 4);
            else bus0.read = 0;
        end
        checks++;
        if (err0 !== 1'b0) begin
            errors++; $display("FAIL b2b_err got %b exp 0", err0);
        end
    endtask

    task automatic test_out_of_range;
        int          st;
        logic [31:0] rd, want;
        do_reset();
        side_load(8'd0, 32'h1111_1111);
        checks++;
        if (err1 !== 1'b0) begin
            errors++; $display("FAIL oor_pre_err got %b exp 0", err1);
        end
        exp_q.push_back(32'h0);
        xfer1(1, 0, 32'h400, 0, 0, st, rd);
        want = exp_q.pop_front();
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL oor_read_data got %h exp %h", rd, want);
        end
        checks++;
        if (err1 !== 1'b1) begin
            errors++; $display("FAIL oor_err got %b exp 1", err1);
        end
        xfer1(0, 1, 32'h400, 32'hFFFF_FFFF, 4'hF, st, rd);
        exp_q.push_back(32'h1111_1111);
        xfer1(1, 0, 32'h0, 0, 0, st, rd);
        want = exp_q.pop_front();
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL oor_write_dropped got %h exp %h", rd, want);
        end
        checks++;
        if (err1 !== 1'b1) begin
            errors++; $display("FAIL oor_err_sticky got %b exp 1", err1);
        end
    endtask

    task automatic test_misaligned;
        int          st;
        logic [31:0] rd, want;
        do_reset();
        side_load(8'd2, 32'hCAFE_F00D);
        exp_q.push_back(32'hCAFE_F00D);
        xfer1(1, 0, 32'h0A, 0, 0, st, rd);
        want = exp_q.pop_front();
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL misalign_data got %h exp %h", rd, want);
        end
        checks++;
        if (err1 !== 1'b1) begin
            errors++; $display("FAIL misalign_err got %b exp 1", err1);
        end
    endtask

    task automatic test_collision;
        int          st;
        logic [31:0] rd, want;
        do_reset();
        side_load(8'd4, 32'h0000_1234);
        exp_q.push_back(32'h0000_1234);
        xfer1(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, st, rd);
        want = exp_q.pop_front();
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL rw_read_data got %h exp %h", rd, want);
        end
        checks++;
        if (err1 !== 1'b1) begin
            errors++; $display("FAIL rw_err got %b exp 1", err1);
        end
        exp_q.push_back(32'h0000_1234);
        xfer1(1, 0, 32'h10, 0, 0, st, rd);
        want = exp_q.pop_front();
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL rw_mem_unchanged got %h exp %h", rd, want);
        end
    endtask

    task automatic test_sideload_wins;
        int          st;
        logic [31:0] rd, want;
        do_reset();
        side_load(8'd7, 32'h7777_7777);
        @(posedge clk);
        #1 bus1.write = 1; bus1.address = 32'h18;
        bus1.writedata = 32'hAAAA_AAAA; bus1.byteenable = 4'hF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus1.waitrequest) break;
        end
        load_en = 1; load_addr = 8'd6; load_data = 32'h6666_6666;
        @(posedge clk);
        #1 bus1.write = 0; load_en = 0;
        exp_q.push_back(32'h6666_6666);
        xfer1(1, 0, 32'h18, 0, 0, st, rd);
        want = exp_q.pop_front();
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL load_wins got %h exp %h", rd, want);
        end
        exp_q.push_back(32'h7777_7777);
        @(posedge clk);
        #1 bus1.read = 1; bus1.address = 32'h1C;
        rd = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus1.waitrequest) begin
                rd = bus1.readdata;
                break;
            end
        end
        load_en = 1; load_addr = 8'd7; load_data = 32'h9999_9999;
        @(posedge clk);
        #1 bus1.read = 0; load_en = 0;
        want = exp_q.pop_front();
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL ack_old_data got %h exp %h", rd, want);
        end
        checks++;
        if (bus1.readdata !== want) begin
            errors++; $display("FAIL ack_hold_data got %h exp %h", bus1.readdata, want);
        end
        exp_q.push_back(32'h9999_9999);
        xfer1(1, 0, 32'h1C, 0, 0, st, rd);
        want = exp_q.pop_front();
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL load_after_ack got %h exp %h", rd, want);
        end
    endtask

    task automatic test_reset_mid;
        int          st;
        logic [31:0] rd, want;
        do_reset();
        @(posedge clk);
        #1 bus1.write = 1; bus1.address = 32'h14;
        bus1.writedata = 32'hDEAD_BEEF; bus1.byteenable = 4'hF;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (bus1.waitrequest !== 1'b0) begin
            errors++; $display("FAIL rst_mid_wait got %b exp 0", bus1.waitrequest);
        end
        bus1.write = 0;
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        checks++;
        if (bus1.waitrequest !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle got %b exp 0", bus1.waitrequest);
        end
        exp_q.push_back(32'h0);
        xfer1(1, 0, 32'h14, 0, 0, st, rd);
        want = exp_q.pop_front();
        checks++;
        if (st !== 2) begin
            errors++; $display("FAIL rst_mid_stall got %0d exp 2", st);
        end
        checks++;
        if (rd !== want) begin
            errors++; $display("FAIL rst_mid_mem got %h exp %h", rd, want);
        end
    endtask

    initial begin
        test_reset();
        test_sideload_read();
        test_byteenable();
        test_back_to_back();
        test_out_of_range();
        test_misaligned();
        test_collision();
        test_sideload_wins();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
